// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the seven-segment display bank.
// Patterns are active-high, bit 0 = a ... bit 6 = g.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_P0 = 7'b0111111;
  localparam seg_t SEG_P1 = 7'b0000110;
  localparam seg_t SEG_P2 = 7'b1011011;
  localparam seg_t SEG_P3 = 7'b1001111;
  localparam seg_t SEG_P4 = 7'b1100110;
  localparam seg_t SEG_P5 = 7'b1101101;
  localparam seg_t SEG_P6 = 7'b1111101;
  localparam seg_t SEG_P7 = 7'b0000111;
  localparam seg_t SEG_P8 = 7'b1111111;
  localparam seg_t SEG_P9 = 7'b1101111;
  localparam seg_t SEG_PA = 7'b1110111;
  localparam seg_t SEG_PB = 7'b1111100;
  localparam seg_t SEG_PC = 7'b0111001;
  localparam seg_t SEG_PD = 7'b1011110;
  localparam seg_t SEG_PE = 7'b1111001;
  localparam seg_t SEG_PF = 7'b1110001;

  function automatic seg_t seg_pattern(input logic [3:0] nibble);
    seg_t pat;
    unique case (nibble)
      4'h0: pat = SEG_P0;
      4'h1: pat = SEG_P1;
      4'h2: pat = SEG_P2;
      4'h3: pat = SEG_P3;
      4'h4: pat = SEG_P4;
      4'h5: pat = SEG_P5;
      4'h6: pat = SEG_P6;
      4'h7: pat = SEG_P7;
      4'h8: pat = SEG_P8;
      4'h9: pat = SEG_P9;
      4'hA: pat = SEG_PA;
      4'hB: pat = SEG_PB;
      4'hC: pat = SEG_PC;
      4'hD: pat = SEG_PD;
      4'hE: pat = SEG_PE;
      4'hF: pat = SEG_PF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-segment decoder, active-low output.
// Values 10..15 decode as hex letters only when hex mode is on.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output seg_t       seg_o
);

  always_comb begin
    if ((nibble_i > 4'd9) && !hex_mode_i) begin
      seg_o = SEG_BLANK;
    end else begin
      seg_o = ~seg_pattern(nibble_i);
    end
  end

endmodule

// File: rtl/seg_bank.sv
// Registered multi-digit seven-segment driver with hex mode, leading-zero
// blanking, per-digit blink and PWM brightness.
module seg_bank
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 6,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic [PWM_BITS-1:0]   bright,
  output logic [7*N_DIGITS-1:0] seg,
  output logic                  blink_phase
);

  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [4*N_DIGITS-1:0] digits_q;
  logic                  hex_mode_q;
  logic                  lz_blank_q;
  logic [N_DIGITS-1:0]   blink_en_q;
  logic [PWM_BITS-1:0]   bright_q;
  logic [BLINK_W-1:0]    blink_cnt_q;
  logic                  blink_phase_q;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [7*N_DIGITS-1:0] seg_q, seg_d;

  seg_t                  dec [N_DIGITS];
  logic [N_DIGITS-1:0]   lz_hide;
  logic                  zero_run;
  logic                  pwm_off;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg_decode u_dec (
      .nibble_i   (digits_q[4*g +: 4]),
      .hex_mode_i (hex_mode_q),
      .seg_o      (dec[g])
    );
  end

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    zero_run = 1'b1;
    lz_hide  = '0;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      zero_run   = zero_run && (digits_q[4*i +: 4] == 4'd0);
      lz_hide[i] = lz_blank_q && zero_run && (i != 0);
    end
  end

  assign pwm_off = (pwm_cnt_q >= bright_q);

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (pwm_off || (blink_en_q[i] && !blink_phase_q) || lz_hide[i]) begin
        seg_d[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_d[7*i +: 7] = dec[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q      <= '0;
      hex_mode_q    <= 1'b0;
      lz_blank_q    <= 1'b0;
      blink_en_q    <= '0;
      bright_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      pwm_cnt_q     <= '0;
      seg_q         <= '1;
    end else begin
      bright_q  <= bright;
      seg_q     <= seg_d;
      pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
      // Load restarts the blink period in the visible phase.
      if (load) begin
        digits_q      <= digits;
        hex_mode_q    <= hex_mode;
        lz_blank_q    <= lz_blank;
        blink_en_q    <= blink_en;
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign seg         = seg_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seg_bank.sv
// Directed bench for seg_bank: vector table for decode/blanking plus
// hand-written blink, PWM, reset and held-load sequences.
module tb_seg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [23:0] digits = '0;
  logic        hex_mode = 1'b0;
  logic        lz_blank = 1'b0;
  logic [5:0]  blink_en = '0;
  logic [1:0]  bright = '0;
  logic [41:0] seg;
  logic        blink_phase;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] SX = 7'h7F;
  localparam logic [6:0] S0 = ~7'b0111111;
  localparam logic [6:0] S1 = ~7'b0000110;
  localparam logic [6:0] S2 = ~7'b1011011;
  localparam logic [6:0] S3 = ~7'b1001111;
  localparam logic [6:0] S4 = ~7'b1100110;
  localparam logic [6:0] S5 = ~7'b1101101;
  localparam logic [6:0] S6 = ~7'b1111101;
  localparam logic [6:0] S7 = ~7'b0000111;
  localparam logic [6:0] S8 = ~7'b1111111;
  localparam logic [6:0] S9 = ~7'b1101111;
  localparam logic [6:0] SA = ~7'b1110111;
  localparam logic [6:0] SB = ~7'b1111100;
  localparam logic [6:0] SC = ~7'b0111001;
  localparam logic [6:0] SD = ~7'b1011110;
  localparam logic [6:0] SE = ~7'b1111001;
  localparam logic [6:0] SF = ~7'b1110001;
  localparam logic [41:0] ALL_BLANK = {6{SX}};
  localparam logic [41:0] ALL_ZERO  = {6{S0}};

  seg_bank #(
    .N_DIGITS  (6),
    .BLINK_DIV (4),
    .PWM_BITS  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .digits      (digits),
    .hex_mode    (hex_mode),
    .lz_blank    (lz_blank),
    .blink_en    (blink_en),
    .bright      (bright),
    .seg         (seg),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] digits;
    logic        hex_mode;
    logic        lz_blank;
    logic [41:0] exp;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [41:0] pack6(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [23:0] d, input logic hm, input logic lz,
                         input logic [5:0] be);
    digits   = d;
    hex_mode = hm;
    lz_blank = lz;
    blink_en = be;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    logic [6:0] held_pat [5];
    int lit;

    vecs[0] = '{24'h012345, 1'b0, 1'b1, pack6(SX, S1, S2, S3, S4, S5)};
    vecs[1] = '{24'h00000A, 1'b0, 1'b0, pack6(S0, S0, S0, S0, S0, SX)};
    vecs[2] = '{24'h00000A, 1'b1, 1'b0, pack6(S0, S0, S0, S0, S0, SA)};
    vecs[3] = '{24'h000000, 1'b0, 1'b1, pack6(SX, SX, SX, SX, SX, S0)};
    vecs[4] = '{24'h00A000, 1'b0, 1'b1, pack6(SX, SX, SX, S0, S0, S0)};
    vecs[5] = '{24'hFEDCBA, 1'b1, 1'b0, pack6(SF, SE, SD, SC, SB, SA)};
    vecs[6] = '{24'h987654, 1'b0, 1'b1, pack6(S9, S8, S7, S6, S5, S4)};
    vecs[7] = '{24'h100000, 1'b1, 1'b1, pack6(S1, S0, S0, S0, S0, S0)};
    held_pat = '{S1, S2, S3, S4, S5};

    bright = 2'd3;
    #12;
    check("reset_seg", 64'(seg), 64'(ALL_BLANK));
    check("reset_phase", 64'(blink_phase), 64'd1);
    rst_n = 1'b1;
    step();
    step();
    check("post_reset_zero", 64'(seg), 64'(ALL_ZERO));

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].digits, vecs[i].hex_mode, vecs[i].lz_blank, 6'b0);
      step();
      check($sformatf("vec%0d", i), 64'(seg), 64'(vecs[i].exp));
    end

    // Blink on digit 0 only, half-period 4 cycles.
    do_load(24'h000005, 1'b0, 1'b0, 6'b000001);
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("blink_seg%0d", j), 64'(seg[6:0]),
            64'(((((j - 1) / 4) % 2) == 0) ? S5 : SX));
      check($sformatf("blink_ph%0d", j), 64'(blink_phase), 64'(((j / 4) % 2) == 0));
      check($sformatf("blink_d1_%0d", j), 64'(seg[13:7]), 64'(S0));
    end
    step();
    check("blink_mid_blank", 64'(seg[6:0]), 64'(SX));
    do_load(24'h000005, 1'b0, 1'b0, 6'b000001);
    check("reload_phase", 64'(blink_phase), 64'd1);
    for (int j = 1; j <= 5; j++) begin
      step();
      check($sformatf("reload_seg%0d", j), 64'(seg[6:0]), 64'((j <= 4) ? S5 : SX));
    end

    // PWM with period 3.
    do_load(24'h000000, 1'b0, 1'b0, 6'b0);
    bright = 2'd0;
    step();
    step();
    for (int j = 0; j < 6; j++) begin
      step();
      check($sformatf("pwm0_%0d", j), 64'(seg), 64'(ALL_BLANK));
    end
    bright = 2'd1;
    step();
    step();
    lit = 0;
    for (int j = 0; j < 9; j++) begin
      step();
      if (seg == ALL_ZERO) lit++;
    end
    check("pwm1_lit", 64'(lit), 64'd3);
    bright = 2'd3;
    step();
    step();
    for (int j = 0; j < 6; j++) begin
      step();
      check($sformatf("pwm3_%0d", j), 64'(seg), 64'(ALL_ZERO));
    end

    // Load held high: 2-edge latency, phase pinned visible.
    load     = 1'b1;
    hex_mode = 1'b1;
    lz_blank = 1'b0;
    blink_en = 6'b000001;
    digits   = 24'h000001;
    step();
    for (int i = 2; i <= 5; i++) begin
      digits = 24'(i);
      step();
      check($sformatf("held_seg%0d", i), 64'(seg), 64'(pack6(S0, S0, S0, S0, S0, held_pat[i-2])));
      check($sformatf("held_ph%0d", i), 64'(blink_phase), 64'd1);
    end
    load = 1'b0;
    step();
    check("held_last", 64'(seg), 64'(pack6(S0, S0, S0, S0, S0, S5)));

    // Reset in the blank half of a blink period.
    for (int j = 0; j < 5; j++) step();
    check("pre_rst_phase", 64'(blink_phase), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_seg", 64'(seg), 64'(ALL_BLANK));
    check("midrst_phase", 64'(blink_phase), 64'd1);
    #2;
    rst_n = 1'b1;
    step();
    step();
    check("midrst_lost", 64'(seg), 64'(ALL_ZERO));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_bank.md
# seg_bank

Parametrised multi-digit seven-segment display driver: latches a packed BCD/hex word on a load strobe, decodes each nibble to active-low segments, and adds hex mode, leading-zero blanking, per-digit blink and PWM brightness. It sits between counting/timekeeping logic (stopwatch, clock, counters) and the board HEX0..HEXn pins, replacing one combinational decoder per digit with a single registered bank.

## Interface
Parameters:
- N_DIGITS, 6, number of digits; digit 0 is least significant (HEX0).
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; at least 2.
- PWM_BITS, 4, brightness resolution; PWM period is 2^PWM_BITS-1 cycles.

Ports:
- clk, input, 1, single clock; all state is in this domain.
- rst_n, input, 1, asynchronous active-low reset.
- load, input, 1, when high, capture digits/hex_mode/lz_blank/blink_en into the shadow registers.
- digits, input, 4*N_DIGITS, packed nibbles; digit i is digits[4i+3:4i].
- hex_mode, input, 1, 1 = decode 10..15 as A b C d E F; 0 = blank them.
- lz_blank, input, 1, 1 = suppress leading zeros.
- blink_en, input, N_DIGITS, per-digit blink enable.
- bright, input, PWM_BITS, live brightness; 0 = dark, all-ones = always lit.
- seg, output, 7*N_DIGITS, active-low segments; digit i is seg[7i+6:7i], bit 0 = a … bit 6 = g.
- blink_phase, output, 1, current blink phase; 1 = visible.

## Operation
- Shadow registers: reset to digits 0, hex_mode 0, lz_blank 0, blink_en 0. They change only on an edge where load = 1; otherwise they hold.
- Decode, with active-high patterns g..a inverted on output:
  - 0 0111111, 1 0000110, 2 1011011, 3 1001111, 4 1100110, 5 1101101, 6 1111101, 7 0000111, 8 1111111, 9 1101111.
  - Hex mode: A 1110111, b 1111100, C 0111001, d 1011110, E 1111001, F 1110001.
  - Values 10..15 with hex_mode = 0 decode to blank (7'h7F).
- Leading-zero blanking: digit i (i ≥ 1) is blank when lz_blank = 1 and digit i and every higher digit are 0. Digit 0 is never blanked by this rule. A nonzero digit 10..15 counts as nonzero even when it decodes to blank.
- Blink counter:
  - Counts 0..BLINK_DIV-1 and wraps to 0.
  - blink_phase toggles on each wrap.
  - Digits with blink_en = 1 are blank while blink_phase = 0.
  - Any load clears the counter to 0 and sets blink_phase to 1.
- PWM counter: free-running 0..2^PWM_BITS-2, then wraps. All segments are forced blank on cycles where counter ≥ bright. bright = 2^PWM_BITS-1 is therefore lit on every cycle; bright = 0 is never lit.
- Blank priority: PWM off, then blink, then leading-zero, then decode. Any one of these forces 7'h7F.

## Timing
- Reset (asynchronous assert): seg = all ones (every digit 7'h7F), blink_phase = 1, blink and PWM counters = 0.
- First edge after rst_n release: seg shows the decode of the reset shadow (all "0", subject to PWM).
- Load latency: load sampled at edge k updates the shadow at edge k. seg reflects the new value after edge k+1, two edges after load is presented.
- bright is registered once, so a bright change takes effect on seg after 2 edges.
- load held high for several cycles recaptures every cycle and holds the blink counter at 0 with phase visible.
- Simultaneous load and blink wrap: load wins; counter = 0, phase = 1.
- Reset mid-operation: immediate blank; shadow contents are lost.
- seg is a pure register output; there is no combinational path from any input to seg.

## Structure
- Package seg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16 active-high segment pattern constants.
  - A typedef for a 7-bit segment vector.
- Sub-module seg_decode: combinational nibble + hex_mode to active-low pattern, instantiated N_DIGITS times via generate.
- Leading-zero chain, blink/PWM counters and the output register live in seg_bank.

## Test plan
- Reset, then load digits = 24'h012345 with lz_blank = 1: two edges later, HEX5 = 7'h7F, HEX4 = ~7'b0000110, HEX0 = ~7'b1101101.
- Load 24'h00000A with hex_mode = 0, then with hex_mode = 1: HEX0 = 7'h7F, then ~7'b1110111. With lz_blank = 1, digit 0 = 0 shows "0".
- BLINK_DIV = 4, blink_en = 6'b000001: HEX0 alternates visible/blank every 4 cycles. A load mid-period restores visible and restarts the count.
- PWM_BITS = 2 (period 3): bright = 0 keeps seg all ones; bright = 1 gives 1 of every 3 cycles lit; bright = 3 is lit every cycle.
- Assert rst_n low mid-blink with digits displayed: seg = all ones immediately without a clock edge, blink_phase = 1.
- Hold load high for 5 cycles with changing digits: seg tracks each value with 2-edge latency, and blink_phase stays 1.
